// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial LSB-first adder built from two half adders per bit.
// Revision    : 1.0 - initial release
// ============================================================================

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_psum;
    logic [CNT_W-1:0]   r_count;
    logic               r_carry;

    logic               w_s1;
    logic               w_c1;
    logic               w_s;
    logic               w_c2;
    logic               w_c;
    logic [WIDTH-1:0]   w_cat;

    half_adder u_ha_ab (
        .x (r_a[0]),
        .y (r_b[0]),
        .s (w_s1),
        .c (w_c1)
    );

    half_adder u_ha_cin (
        .x (w_s1),
        .y (r_carry),
        .s (w_s),
        .c (w_c2)
    );

    assign w_c   = w_c1 | w_c2;
    // Partial sum holds the WIDTH-1 bits already produced; the new bit joins at the MSB.
    assign w_cat = {w_s, r_psum};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= 1'b0;
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= S_ADD;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_psum  <= w_cat[WIDTH-1:1];
                    r_carry <= w_c;
                    r_count <= r_count + 1'b1;
                    if (r_count == C_LAST) begin
                        sum     <= w_cat;
                        cout    <= w_c;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_serial_adder;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int passed = 0;
    int total  = 0;
    logic [WIDTH:0] held = '0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // One complete addition: pulse start, watch busy for WIDTH cycles, then done.
    task automatic do_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input string tag);
        a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        for (int i = 0; i < WIDTH; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_held"}, 32'({cout, sum}), 32'(held));
            tick();
        end
        held = model(x, y);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_idlebusy"}, 32'(busy), 32'd0);
        check({tag, "_result"}, 32'({cout, sum}), 32'(held));
        tick();
        check({tag, "_donepulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);

        do_add(4'd3,  4'd5,  "add_3_5");
        do_add(4'd15, 4'd1,  "add_15_1");
        do_add(4'd15, 4'd15, "add_15_15");
        do_add(4'd0,  4'd0,  "add_0_0");

        // Operands and start changes during ADD are ignored
        a = 4'd6; b = 4'd7; start = 1'b1;
        tick();
        start = 1'b0; a = 4'd1; b = 4'd1;
        for (int i = 0; i < WIDTH; i++) begin
            check("ign_busy", 32'(busy), 32'd1);
            start = (i == 1 || i == 3);
            tick();
            start = 1'b0;
        end
        held = model(4'd6, 4'd7);
        check("ign_done", 32'(done), 32'd1);
        check("ign_result", 32'({cout, sum}), 32'(held));
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            check("ign_noextra_done", 32'(done), 32'd0);
            check("ign_noextra_busy", 32'(busy), 32'd0);
        end

        // Reset mid-ADD aborts with no done
        a = 4'd9; b = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        held = '0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            check("abort_nodone", 32'(done), 32'd0);
            check("abort_held", 32'({cout, sum}), 32'(held));
        end

        // Back-to-back: second operation accepted in the DONE cycle
        a = 4'd2; b = 4'd3; start = 1'b1;
        tick();
        for (int i = 0; i < WIDTH; i++) begin
            check("b2b_busy1", 32'(busy), 32'd1);
            tick();
        end
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_res1", 32'({cout, sum}), 32'(model(4'd2, 4'd3)));
        a = 4'd12; b = 4'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            check("b2b_busy2", 32'(busy), 32'd1);
            check("b2b_gap", 32'(done), 32'd0);
            if (i < WIDTH - 1) tick();
        end
        tick();
        held = model(4'd12, 4'd4);
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_res2", 32'({cout, sum}), 32'(held));
        tick();

        // Randomized operands
        for (int n = 0; n < 30; n++)
            do_add(WIDTH'($urandom), WIDTH'($urandom_range(0, 15)), "rand");

        // Exhaustive sweep
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                do_add(WIDTH'(x), WIDTH'(y), "exh");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
